dram_arbiter: RTL

- Shares the single-port data RAM (d_ram) between two requesters: the pipeline memory-access stage (CPU port) and a debug port used by system view, the display and a test loader.
- The CPU has fixed priority. A starvation counter forces a debug slot and stalls the pipeline for one cycle when needed.
- Sits between memory_access_d_ram and d_ram at top level. Runs on the same clock as d_ram; d_ram has 1-cycle read latency.

---
 rtl/xm23_mem_pkg.sv | 28 ++
 rtl/dram_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/xm23_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xm23_mem_pkg
// Purpose  : Shared widths and state encodings for the XM23 data-RAM path.
// Revision : 1.0  initial release
// ============================================================================
package xm23_mem_pkg;

  localparam int XM23_DADDR_W = 15;
  localparam int XM23_DATA_W  = 16;

  // Debug-access sequencer states of the data-RAM arbiter.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_ISSUE   = 3'd2,
    S_CAPTURE = 3'd3,
    S_ACK     = 3'd4
  } arb_state_t;

  // Which requester owned the RAM in a given cycle.
  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_DBG = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_arbiter
// Purpose  : Shares the single-port data RAM between the pipeline (fixed
//            priority) and a debug port, with a starvation counter that
//            forces a debug slot and stalls the CPU for one cycle.
// Revision : 1.0  initial release
// ============================================================================
module dram_arbiter
  import xm23_mem_pkg::*;
#(
  parameter int ADDR_W   = XM23_DADDR_W,
  parameter int DATA_W   = XM23_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              init,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_wren,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              dbg_busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  // Last WAIT count before the debug access is forced through.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  arb_state_t        state_q,     state_d;
  logic [7:0]        wait_cnt_q,  wait_cnt_d;
  grant_t            last_grant_q, last_grant_d;
  logic              req_wren_q,  req_wren_d;
  logic [ADDR_W-1:0] req_addr_q,  req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  // State, counter, captured request and read-back register update.
  always_ff @(posedge clk) begin
    if (init) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      last_grant_q <= GRANT_CPU;
      req_wren_q   <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      last_grant_q <= last_grant_d;
      req_wren_q   <= req_wren_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Next-state logic of the debug sequencer and starvation counter.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    req_wren_d  = req_wren_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    dbg_rdata_d = dbg_rdata_q;
    last_grant_d = (state_q == S_ISSUE) ? GRANT_DBG : GRANT_CPU;
    case (state_q)
      S_IDLE: begin
        if (dbg_req) begin
          req_wren_d  = dbg_wren;
          req_addr_d  = dbg_addr;
          req_wdata_d = dbg_wdata;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // CPU keeps priority until it goes idle or the limit is reached.
        if (!cpu_req || (wait_cnt_q == WAIT_LAST)) begin
          state_d = S_ISSUE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_CAPTURE;
      end
      S_CAPTURE: begin
        // ram_q now holds the data addressed during ISSUE.
        if (!req_wren_q) begin
          dbg_rdata_d = ram_q;
        end
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // RAM port mux: debug owns the RAM only in ISSUE; init blocks any write.
  always_comb begin
    ram_address = cpu_addr;
    ram_data    = cpu_wdata;
    ram_wren    = cpu_req & cpu_wren;
    cpu_stall   = 1'b0;
    if (init) begin
      ram_address = '0;
      ram_data    = '0;
      ram_wren    = 1'b0;
    end else if (state_q == S_ISSUE) begin
      ram_address = req_addr_q;
      ram_data    = req_wdata_q;
      ram_wren    = req_wren_q;
      cpu_stall   = cpu_req;
    end
  end

  assign cpu_rdata = ram_q;
  assign dbg_rdata = dbg_rdata_q;
  assign dbg_ack   = (state_q == S_ACK) && !init;
  assign dbg_busy  = (state_q != S_IDLE);

  // A debug grant is always followed by the capture cycle.
  a_dbg_grant_then_capture: assert property (
    @(posedge clk) disable iff (init)
      (last_grant_q == GRANT_DBG) |-> (state_q == S_CAPTURE)
  );

endmodule
`default_nettype wire
